// File: rtl/alu_issue.sv
// Initiator-side sequencer for the ALU command interface: issues one request at a
// time, splits 128-bit add/sub into two chained 64-bit passes, and times out a silent ALU.
module alu_issue #(
  parameter int LEN_DATA     = 64,
  parameter int LEN_TYPE_ALU = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [LEN_TYPE_ALU-1:0] req_code,
  input  logic [2*LEN_DATA-1:0]   req_a,
  input  logic [2*LEN_DATA-1:0]   req_b,
  input  logic                    req_cin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*LEN_DATA-1:0]   rsp_result,
  output logic                    rsp_cout,
  output logic                    rsp_err,
  output logic                    alu_en,
  output logic [LEN_TYPE_ALU-1:0] alu_code,
  output logic [LEN_DATA-1:0]     alu_a,
  output logic [LEN_DATA-1:0]     alu_b,
  output logic                    alu_cin,
  input  logic [LEN_DATA-1:0]     alu_result,
  input  logic                    alu_cout,
  input  logic                    alu_rdy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE_LO = 3'd1;
  localparam logic [2:0] S_WAIT_LO  = 3'd2;
  localparam logic [2:0] S_ISSUE_HI = 3'd3;
  localparam logic [2:0] S_WAIT_HI  = 3'd4;
  localparam logic [2:0] S_RESP     = 3'd5;

  localparam int                    CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]         CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [LEN_TYPE_ALU-1:0] C_ADD64  = LEN_TYPE_ALU'(1);
  localparam logic [LEN_TYPE_ALU-1:0] C_ADD128 = LEN_TYPE_ALU'(12);
  localparam logic [LEN_TYPE_ALU-1:0] C_SUB128 = LEN_TYPE_ALU'(13);

  logic [2:0]              r_state;
  logic [LEN_TYPE_ALU-1:0] r_code;
  logic [LEN_DATA-1:0]     r_a_hi;
  logic [LEN_DATA-1:0]     r_b_hi;
  logic [LEN_DATA-1:0]     r_lo;
  logic [CW-1:0]           r_cnt;
  logic [2*LEN_DATA-1:0]   r_rsp_result;
  logic                    r_rsp_cout;
  logic                    r_rsp_err;
  logic                    r_alu_en;
  logic [LEN_TYPE_ALU-1:0] r_alu_code;
  logic [LEN_DATA-1:0]     r_alu_a;
  logic [LEN_DATA-1:0]     r_alu_b;
  logic                    r_alu_cin;

  logic w_req_legal;
  logic w_req_wide;
  logic w_req_sub;
  logic w_wide;
  logic w_sub;
  logic w_timeout;

  assign w_req_legal = (req_code != '0) && (req_code <= C_SUB128);
  assign w_req_wide  = (req_code == C_ADD128) || (req_code == C_SUB128);
  assign w_req_sub   = (req_code == C_SUB128);
  assign w_wide      = (r_code == C_ADD128) || (r_code == C_SUB128);
  assign w_sub       = (r_code == C_SUB128);
  assign w_timeout   = (r_cnt == CNT_LAST);

  assign req_ready  = rst && (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_result = r_rsp_result;
  assign rsp_cout   = r_rsp_cout;
  assign rsp_err    = r_rsp_err;
  assign alu_en     = r_alu_en;
  assign alu_code   = r_alu_code;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_cin    = r_alu_cin;

  // ALU drive registers are loaded on the edge entering an ISSUE state so that
  // alu_en and its operands are valid for exactly that state and held afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_code       <= '0;
      r_a_hi       <= '0;
      r_b_hi       <= '0;
      r_lo         <= '0;
      r_cnt        <= '0;
      r_rsp_result <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_alu_en     <= 1'b0;
      r_alu_code   <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_cin    <= 1'b0;
    end else begin
      r_alu_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_code <= req_code;
            r_a_hi <= req_a[2*LEN_DATA-1:LEN_DATA];
            r_b_hi <= req_b[2*LEN_DATA-1:LEN_DATA];
            if (!w_req_legal) begin
              r_rsp_result <= '0;
              r_rsp_cout   <= 1'b0;
              r_rsp_err    <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_alu_en   <= 1'b1;
              r_alu_code <= w_req_wide ? C_ADD64 : req_code;
              r_alu_a    <= req_a[LEN_DATA-1:0];
              r_alu_b    <= w_req_sub ? ~req_b[LEN_DATA-1:0] : req_b[LEN_DATA-1:0];
              r_alu_cin  <= w_req_wide ? w_req_sub : req_cin;
              r_cnt      <= '0;
              r_state    <= S_ISSUE_LO;
            end
          end
        end
        S_ISSUE_LO: r_state <= S_WAIT_LO;
        S_WAIT_LO: begin
          if (alu_rdy) begin
            if (w_wide) begin
              // Low-half carry chains straight into the high pass.
              r_lo       <= alu_result;
              r_alu_en   <= 1'b1;
              r_alu_code <= C_ADD64;
              r_alu_a    <= r_a_hi;
              r_alu_b    <= w_sub ? ~r_b_hi : r_b_hi;
              r_alu_cin  <= alu_cout;
              r_cnt      <= '0;
              r_state    <= S_ISSUE_HI;
            end else begin
              r_rsp_result <= {{LEN_DATA{1'b0}}, alu_result};
              r_rsp_cout   <= alu_cout;
              r_rsp_err    <= 1'b0;
              r_state      <= S_RESP;
            end
          end else if (w_timeout) begin
            r_rsp_result <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_err    <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ISSUE_HI: r_state <= S_WAIT_HI;
        S_WAIT_HI: begin
          if (alu_rdy) begin
            r_rsp_result <= {alu_result, r_lo};
            r_rsp_cout   <= alu_cout;
            r_rsp_err    <= 1'b0;
            r_state      <= S_RESP;
          end else if (w_timeout) begin
            r_rsp_result <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_err    <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU of programmable latency.
module tb_alu_issue;
  localparam int LD = 64;
  localparam int LT = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [LT-1:0]  req_code = '0;
  logic [2*LD-1:0] req_a = '0;
  logic [2*LD-1:0] req_b = '0;
  logic           req_cin = 1'b0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2*LD-1:0] rsp_result;
  logic           rsp_cout;
  logic           rsp_err;
  logic           alu_en;
  logic [LT-1:0]  alu_code;
  logic [LD-1:0]  alu_a;
  logic [LD-1:0]  alu_b;
  logic           alu_cin;
  logic [LD-1:0]  alu_result = '0;
  logic           alu_cout = 1'b0;
  logic           alu_rdy = 1'b0;

  always #5 clk = ~clk;

  alu_issue #(.LEN_DATA(LD), .LEN_TYPE_ALU(LT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .alu_en(alu_en), .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_result(alu_result), .alu_cout(alu_cout), .alu_rdy(alu_rdy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bench ALU: code 1 is a 64-bit add; other codes return (a^b)+code, no carry.
  int alu_lat = 1;
  bit alu_mute = 1'b0;
  int cd = 0;
  logic [LD-1:0] p_res = '0;
  logic          p_cout = 1'b0;

  function automatic logic [LD:0] alu_fn(input logic [LT-1:0] c, input logic [LD-1:0] a,
                                         input logic [LD-1:0] b, input logic ci);
    if (c == 4'd1) return {1'b0, a} + {1'b0, b} + {{LD{1'b0}}, ci};
    return {1'b0, (a ^ b) + {{(LD-LT){1'b0}}, c}};
  endfunction

  always @(posedge clk) begin
    alu_rdy <= 1'b0;
    if (alu_en && !alu_mute) begin
      if (alu_lat == 1) begin
        alu_rdy    <= 1'b1;
        {alu_cout, alu_result} <= alu_fn(alu_code, alu_a, alu_b, alu_cin);
      end else begin
        cd <= alu_lat - 1;
        {p_cout, p_res} <= alu_fn(alu_code, alu_a, alu_b, alu_cin);
      end
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        alu_rdy    <= 1'b1;
        alu_result <= p_res;
        alu_cout   <= p_cout;
      end
    end
  end

  typedef struct {
    logic [3:0]   code;
    logic [127:0] a, b;
    logic         cin;
    int           lat;
    bit           mute;
    logic [127:0] res;
    logic         cout, err;
    int           en, lt;
    logic [3:0]   c0;
    logic [63:0]  a0, b0;
    logic         cin0;
    logic [63:0]  a1, b1;
    logic         cin1;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] code, input logic [127:0] a, input logic [127:0] b,
      input logic cin, input int lat, input bit mute, input logic [127:0] res, input logic cout,
      input logic err, input int en, input int lt, input logic [3:0] c0, input logic [63:0] a0,
      input logic [63:0] b0, input logic cin0, input logic [63:0] a1, input logic [63:0] b1,
      input logic cin1);
    vec_t v;
    v.code = code; v.a = a; v.b = b; v.cin = cin; v.lat = lat; v.mute = mute;
    v.res = res; v.cout = cout; v.err = err; v.en = en; v.lt = lt;
    v.c0 = c0; v.a0 = a0; v.b0 = b0; v.cin0 = cin0; v.a1 = a1; v.b1 = b1; v.cin1 = cin1;
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, " req_ready"},  128'(req_ready),  128'd0);
    chk({tag, " rsp_valid"},  128'(rsp_valid),  128'd0);
    chk({tag, " rsp_result"}, rsp_result,       128'd0);
    chk({tag, " rsp_cout"},   128'(rsp_cout),   128'd0);
    chk({tag, " rsp_err"},    128'(rsp_err),    128'd0);
    chk({tag, " alu_en"},     128'(alu_en),     128'd0);
    chk({tag, " alu_code"},   128'(alu_code),   128'd0);
    chk({tag, " alu_a"},      128'(alu_a),      128'd0);
    chk({tag, " alu_b"},      128'(alu_b),      128'd0);
    chk({tag, " alu_cin"},    128'(alu_cin),    128'd0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " req_ready"}, 128'(req_ready), 128'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int en_cnt = 0;
    int lat = 0;
    bit got = 1'b0;
    logic [63:0] ea [2] = '{64'd0, 64'd0};
    logic [63:0] eb [2] = '{64'd0, 64'd0};
    logic [3:0]  ec [2] = '{4'd0, 4'd0};
    logic        ei [2] = '{1'b0, 1'b0};
    string t = $sformatf("v%0d", idx);
    alu_lat  = v.lat;
    alu_mute = v.mute;
    @(negedge clk);
    req_valid = 1'b1; req_code = v.code; req_a = v.a; req_b = v.b; req_cin = v.cin;
    rsp_ready = 1'b1;
    wait_ready(t);
    @(posedge clk);
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (alu_en) begin
        if (en_cnt < 2) begin
          ea[en_cnt] = alu_a; eb[en_cnt] = alu_b; ec[en_cnt] = alu_code; ei[en_cnt] = alu_cin;
        end
        en_cnt++;
      end
      if (rsp_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk({t, " rsp_valid"},  128'(got),      128'd1);
    chk({t, " rsp_result"}, rsp_result,     v.res);
    chk({t, " rsp_cout"},   128'(rsp_cout), 128'(v.cout));
    chk({t, " rsp_err"},    128'(rsp_err),  128'(v.err));
    chk({t, " en_pulses"},  128'(en_cnt),   128'(v.en));
    if (v.lt != 0) chk({t, " latency"}, 128'(lat), 128'(v.lt));
    if (v.en >= 1) begin
      chk({t, " code0"}, 128'(ec[0]), 128'(v.c0));
      chk({t, " a0"},    128'(ea[0]), 128'(v.a0));
      chk({t, " b0"},    128'(eb[0]), 128'(v.b0));
      chk({t, " cin0"},  128'(ei[0]), 128'(v.cin0));
    end
    if (v.en >= 2) begin
      chk({t, " code1"}, 128'(ec[1]), 128'd1);
      chk({t, " a1"},    128'(ea[1]), 128'(v.a1));
      chk({t, " b1"},    128'(eb[1]), 128'(v.b1));
      chk({t, " cin1"},  128'(ei[1]), 128'(v.cin1));
    end
    @(posedge clk);
  endtask

  localparam logic [63:0]  ONES64  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] ONES128 = {2{64'hFFFF_FFFF_FFFF_FFFF}};

  vec_t vecs [12];

  initial begin
    //            code a                                 b                      cin lat mute res                          cout err en lt  c0 a0      b0                      cin0 a1      b1      cin1
    vecs[0]  = mk(1,  {64'd0, ONES64},                   128'd1,                0,  2,  0,   128'd0,                      1,   0,  1, 4,  1, ONES64, 64'd1,                  0,   64'd0,  64'd0,  0);
    vecs[1]  = mk(1,  {64'hDEAD_BEEF_0000_0000, 64'd5},  {64'h1234, 64'd7},     1,  1,  0,   128'hD,                      0,   0,  1, 3,  1, 64'd5,  64'd7,                  1,   64'd0,  64'd0,  0);
    vecs[2]  = mk(12, {64'd1, ONES64},                   128'd1,                0,  2,  0,   {64'd2, 64'd0},              0,   0,  2, 7,  1, ONES64, 64'd1,                  0,   64'd1,  64'd0,  1);
    vecs[3]  = mk(13, 128'd0,                            128'd1,                0,  1,  0,   ONES128,                     0,   0,  2, 5,  1, 64'd0,  64'hFFFF_FFFF_FFFF_FFFE, 1,   64'd0,  ONES64, 0);
    vecs[4]  = mk(13, 128'd5,                            128'd3,                0,  1,  0,   128'd2,                      1,   0,  2, 5,  1, 64'd5,  64'hFFFF_FFFF_FFFF_FFFC, 1,   64'd0,  ONES64, 1);
    vecs[5]  = mk(12, ONES128,                           128'd1,                1,  1,  0,   128'd0,                      1,   0,  2, 5,  1, ONES64, 64'd1,                  0,   ONES64, 64'd0,  1);
    vecs[6]  = mk(9,  128'h0F,                           128'hF0,               0,  2,  0,   128'h108,                    0,   0,  1, 4,  9, 64'h0F, 64'hF0,                 0,   64'd0,  64'd0,  0);
    vecs[7]  = mk(11, 128'h10,                           128'h01,               1,  3,  0,   128'h1C,                     0,   0,  1, 5, 11, 64'h10, 64'h01,                 1,   64'd0,  64'd0,  0);
    vecs[8]  = mk(14, 128'd5,                            128'd6,                0,  1,  0,   128'd0,                      0,   1,  0, 1,  0, 64'd0,  64'd0,                  0,   64'd0,  64'd0,  0);
    vecs[9]  = mk(0,  128'd5,                            128'd6,                0,  1,  0,   128'd0,                      0,   1,  0, 1,  0, 64'd0,  64'd0,                  0,   64'd0,  64'd0,  0);
    vecs[10] = mk(15, ONES128,                           ONES128,               1,  1,  0,   128'd0,                      0,   1,  0, 1,  0, 64'd0,  64'd0,                  0,   64'd0,  64'd0,  0);
    vecs[11] = mk(9,  128'd3,                            128'd4,                0,  1,  1,   128'd0,                      0,   1,  1, 0,  9, 64'd3,  64'd4,                  0,   64'd0,  64'd0,  0);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("post-reset req_ready", 128'(req_ready), 128'd1);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Backpressure: response must hold while req_valid stays high.
    begin
      bit got = 1'b0;
      alu_lat = 1; alu_mute = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_code = 4'd1; req_a = 128'd3; req_b = 128'd4; req_cin = 1'b0;
      rsp_ready = 1'b0;
      wait_ready("bp first");
      @(posedge clk);
      @(negedge clk);
      req_a = 128'd10; req_b = 128'd20;
      for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("bp c%0d req_ready", i),  128'(req_ready), 128'd0);
        chk($sformatf("bp c%0d rsp_valid", i),  128'(rsp_valid), 128'd1);
        chk($sformatf("bp c%0d rsp_result", i), rsp_result,      128'd7);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp next req_ready", 128'(req_ready), 128'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        if (rsp_valid) got = 1'b1;
        else @(negedge clk);
      end
      chk("bp second rsp_valid",  128'(got),  128'd1);
      chk("bp second rsp_result", rsp_result, 128'd30);
      @(posedge clk);
    end

    // Reset during WAIT_HI of an ADD128; the late alu_rdy must be ignored.
    begin
      int en_cnt = 0;
      bit seen = 1'b0;
      alu_lat = 3; alu_mute = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_code = 4'd12; req_a = {64'd1, ONES64}; req_b = 128'd1; req_cin = 1'b0;
      rsp_ready = 1'b1;
      wait_ready("rst-mid");
      @(posedge clk);
      for (int k = 1; k <= 30 && en_cnt < 2; k++) begin
        @(negedge clk);
        if (k == 1) req_valid = 1'b0;
        if (alu_en) en_cnt++;
      end
      chk("rst-mid second issue", 128'(en_cnt), 128'd2);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("rst-mid");
      rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
      end
      chk("rst-mid no response", 128'(seen),      128'd0);
      chk("rst-mid idle ready",  128'(req_ready), 128'd1);
    end

    run_vec(100, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
